// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          INSN_W   = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSN_W-1:0] ins;
        logic [INSN_W-1:0] pc_plus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {instruction, pc+4} feeding IF/ID; head reads as all-zero (NOP) when empty.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot0_q;
    fetch_entry_t slot1_q;
    logic [1:0]   count_q;
    logic         do_pop;

    assign do_pop = pop && (count_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) slot0_q <= push_data;
                    else                 slot1_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    slot0_q <= slot1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the new word lands behind whatever survives the pop
                    if (count_q == 2'd2) begin
                        slot0_q <= slot1_q;
                        slot1_q <= push_data;
                    end else begin
                        slot0_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = (count_q != 2'd0) ? slot0_q : '0;
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack FSM and IF/ID output queue.
// Optional statistics counters are enabled with the IF_FETCH_STATS_EN macro.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request outstanding, returned word will be queued
// DRAIN | request outstanding after a redirect, returned word is dropped
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_out,
    output logic [31:0] PCPlus4_out,
    output logic        ins_valid
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_bubbles
`endif
);

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  kill_q, kill_d;
    logic         push;
    logic         pop;
    logic         slot_free;
    logic [1:0]   count;
    logic [2:0]   occ_next;
    fetch_entry_t push_data;
    fetch_entry_t head;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign push      = (state_q == WAIT) && imem_ack && !redirect_valid;
    assign pop       = ins_valid && !stall;
    assign occ_next  = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    // a new request may only go out if its word is guaranteed a slot on arrival
    assign slot_free = (occ_next + 3'd1) <= DEPTH;
    assign push_data = {imem_rdata, pc_q + PC_INC};

    fetch_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            kill_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            case (state_q)
                WAIT: begin
                    if (imem_ack) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                        kill_d  = pc_q;
                    end
                end
                DRAIN:   state_d = imem_ack ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                WAIT: begin
                    if (imem_ack) begin
                        pc_d    = pc_q + PC_INC;
                        state_d = slot_free ? WAIT : IDLE;
                    end
                end
                DRAIN: begin
                    if (imem_ack) state_d = IDLE;
                end
                default: state_d = slot_free ? WAIT : IDLE;
            endcase
        end
    end

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = (state_q == DRAIN) ? kill_q : pc_q;
    assign ins_valid   = (count != 2'd0);
    assign ins_out     = head.ins;
    assign PCPlus4_out = head.pc_plus4;

`ifdef IF_FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_bubbles <= '0;
        end else begin
            if (push)                stat_fetched <= stat_fetched + 32'd1;
            if (!ins_valid && !stall) stat_bubbles <= stat_bubbles + 32'd1;
        end
    end
`endif

endmodule
